// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout and
// bubble encoding, plus the per-edge action type used by the stage.
package id_ex_stage_pkg;

    localparam int CTRL_W = 15;

    // Bit positions inside the packed control bundle
    localparam int C_REGDST   = 14;
    localparam int C_ALUSRC   = 13;
    localparam int C_MEMTOREG = 12;
    localparam int C_REGWRITE = 11;
    localparam int C_MEMREAD  = 10;
    localparam int C_MEMWRITE = 9;
    localparam int C_BRANCH   = 8;
    localparam int C_ALUOP_HI = 7;
    localparam int C_ALUOP_LO = 5;
    localparam int C_JUMP     = 4;
    localparam int C_JR       = 3;
    localparam int C_JAL      = 2;
    localparam int C_BNE      = 1;
    localparam int C_SLIDE    = 0;

    // All-zero bundle: no write, no memory access, no control transfer
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_STALL
    } act_e;

    function automatic logic is_bubble_act(act_e a);
        return (a == ACT_FLUSH) || (a == ACT_STALL);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector (pure combinational).
// Ports: ex_valid_i/ex_memread_i/ex_rt_i describe EX; id_* describe ID;
//        haz_o is high when ID reads the register a load in EX writes.
module hazard_detect #(
    parameter int RW = 5
) (
    input  logic          ex_valid_i,
    input  logic          ex_memread_i,
    input  logic [RW-1:0] ex_rt_i,
    input  logic          id_valid_i,
    input  logic          id_uses_rt_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    output logic          haz_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rt_i == id_rs_i);
    assign rt_hit = id_uses_rt_i & (ex_rt_i == id_rt_i);

    // $0 is hardwired, so a load targeting it never creates a dependency
    assign haz_o = ex_valid_i & ex_memread_i & (ex_rt_i != '0)
                 & (rs_hit | rt_hit) & id_valid_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Ports: clk, rstn (async low); hold_i freezes all state; flush_i squashes
//   ID; id_* are decoder outputs; ex_* are their registered copies with
//   ex_valid_o; stall_o freezes PC and IF/ID. With ID_EX_PERF_CNT_EN
//   defined, bubble_cnt_o counts inserted bubbles (wrapping, 32 bit).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              id_uses_rt_i,
    input  logic [RW-1:0]     id_rs_i,
    input  logic [RW-1:0]     id_rt_i,
    input  logic [RW-1:0]     id_rd_i,
    input  logic [DW-1:0]     id_rd1_i,
    input  logic [DW-1:0]     id_rd2_i,
    input  logic [DW-1:0]     id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [DW-1:0]     id_pc4_i,
    output logic              ex_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_uses_rt_o,
    output logic [RW-1:0]     ex_rs_o,
    output logic [RW-1:0]     ex_rt_o,
    output logic [RW-1:0]     ex_rd_o,
    output logic [DW-1:0]     ex_rd1_o,
    output logic [DW-1:0]     ex_rd2_o,
    output logic [DW-1:0]     ex_imm_o,
    output logic [4:0]        ex_shamt_o,
    output logic [DW-1:0]     ex_pc4_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       bubble_cnt_o,
`endif
    output logic              stall_o
);

    localparam int PW = 1 + 3*RW + 4*DW + 5;

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [PW-1:0]     pay_q, pay_d, pay_in;
    logic              haz;
    act_e              act;

    // Operand/index payload travels as one flat vector
    assign pay_in = {id_uses_rt_i, id_rs_i, id_rt_i, id_rd_i,
                     id_rd1_i, id_rd2_i, id_imm_i, id_shamt_i, id_pc4_i};

    assign {ex_uses_rt_o, ex_rs_o, ex_rt_o, ex_rd_o,
            ex_rd1_o, ex_rd2_o, ex_imm_o, ex_shamt_o, ex_pc4_o} = pay_q;
    assign ex_valid_o = valid_q;
    assign ex_ctrl_o  = ctrl_q;

    hazard_detect #(.RW(RW)) u_hazard_detect (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q[C_MEMREAD]),
        .ex_rt_i      (ex_rt_o),
        .id_valid_i   (id_valid_i),
        .id_uses_rt_i (id_uses_rt_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .haz_o        (haz)
    );

    // Flush outranks hold, which outranks the load-use bubble
    always_comb begin
        act = ACT_CAPTURE;
        if (flush_i)     act = ACT_FLUSH;
        else if (hold_i) act = ACT_HOLD;
        else if (haz)    act = ACT_STALL;
    end

    assign stall_o = haz & ~flush_i & ~hold_i;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pay_d   = pay_q;
        unique case (act)
            ACT_FLUSH, ACT_STALL: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
                pay_d   = '0;
            end
            ACT_HOLD: begin
                valid_d = valid_q;
            end
            default: begin
                valid_d = id_valid_i;
                ctrl_d  = id_valid_i ? id_ctrl_i : CTRL_BUBBLE;
                pay_d   = pay_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pay_q   <= pay_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = is_bubble_act(act) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bubble_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model plus
// per-cycle comparison and directed scenarios.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hold_i = 1'b0, flush_i = 1'b0;
    logic        id_valid_i = 1'b0, id_uses_rt_i = 1'b0;
    logic [14:0] id_ctrl_i = '0;
    logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0, id_shamt_i = '0;
    logic [31:0] id_rd1_i = '0, id_rd2_i = '0, id_imm_i = '0, id_pc4_i = '0;

    logic        ex_valid_o, ex_uses_rt_o, stall_o;
    logic [14:0] ex_ctrl_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o;
    logic [31:0] ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_o;
`endif

    int vec = 0;
    int bad = 0;

    localparam logic [14:0] ADDI = 15'h2860;
    localparam logic [14:0] LW   = 15'h3C00;
    localparam logic [14:0] ADD  = 15'h4840;
    localparam logic [14:0] ORI  = 15'h2880;

    id_ex_stage dut (
        .clk(clk), .rstn(rstn), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_uses_rt_i(id_uses_rt_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_rd1_i(id_rd1_i),
        .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
        .id_shamt_i(id_shamt_i), .id_pc4_i(id_pc4_i),
        .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_uses_rt_o(ex_uses_rt_o), .ex_rs_o(ex_rs_o),
        .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_rd1_o(ex_rd1_o),
        .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o),
        .ex_shamt_o(ex_shamt_o), .ex_pc4_o(ex_pc4_o),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt_o(bubble_cnt_o),
`endif
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        vec++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Reference model: what EX must hold, derived from the stage rules
    logic        m_valid, m_uses;
    logic [14:0] m_ctrl;
    logic [4:0]  m_rs, m_rt, m_rd, m_sh;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc4, m_cnt;
    logic [31:0] cnt_ofs = '0;

    // A valid load in EX writes a nonzero register that ID reads
    function automatic logic m_haz();
        logic reads;
        reads = (m_rt == id_rs_i) || (id_uses_rt_i && m_rt == id_rt_i);
        return m_valid && m_ctrl[10] && m_rt != 0 && id_valid_i && reads;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 0; m_ctrl <= 0; m_uses <= 0; m_rs <= 0;
            m_rt <= 0; m_rd <= 0; m_sh <= 0; m_rd1 <= 0;
            m_rd2 <= 0; m_imm <= 0; m_pc4 <= 0; m_cnt <= 0;
        end else if (flush_i || (!hold_i && m_haz())) begin
            m_valid <= 0;
            m_ctrl  <= 0;
            m_cnt   <= m_cnt + 1;
        end else if (!hold_i) begin
            m_valid <= id_valid_i;
            m_ctrl  <= id_valid_i ? id_ctrl_i : 15'h0;
            m_uses <= id_uses_rt_i; m_rs <= id_rs_i; m_rt <= id_rt_i;
            m_rd <= id_rd_i; m_sh <= id_shamt_i; m_rd1 <= id_rd1_i;
            m_rd2 <= id_rd2_i; m_imm <= id_imm_i; m_pc4 <= id_pc4_i;
        end
    end

    always @(negedge clk) begin
        chk("valid", ex_valid_o, m_valid);
        chk("ctrl", ex_ctrl_o, m_ctrl);
        chk("stall", stall_o, m_haz() && !flush_i && !hold_i);
        if (m_valid) begin
            chk("uses_rt", ex_uses_rt_o, m_uses);
            chk("rs", ex_rs_o, m_rs);
            chk("rt", ex_rt_o, m_rt);
            chk("rd", ex_rd_o, m_rd);
            chk("shamt", ex_shamt_o, m_sh);
            chk("rd1", ex_rd1_o, m_rd1);
            chk("rd2", ex_rd2_o, m_rd2);
            chk("imm", ex_imm_o, m_imm);
            chk("pc4", ex_pc4_o, m_pc4);
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("cnt", bubble_cnt_o, m_cnt + cnt_ofs);
`endif
    end

    task automatic idv(input logic [14:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic u);
        id_valid_i = 1; id_ctrl_i = c; id_rs_i = rs; id_rt_i = rt;
        id_rd_i = rd; id_uses_rt_i = u;
        id_rd1_i = $urandom; id_rd2_i = $urandom;
        id_imm_i = $urandom; id_pc4_i = $urandom;
        id_shamt_i = 5'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm, input logic [31:0] e);
`ifdef ID_EX_PERF_CNT_EN
        chk(nm, bubble_cnt_o, e);
`else
        if (e == 32'hDEAD_BEEF) $display("unused %s", nm);
`endif
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            idv(15'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 1'($urandom));
            hold_i = 1'($urandom); flush_i = 1'($urandom);
            tick();
        end
        chk("rst_valid", ex_valid_o, 0);
        chk("rst_ctrl", ex_ctrl_o, 0);
        chk("rst_imm", ex_imm_o, 0);
        chk("rst_pc4", ex_pc4_o, 0);
        chk("rst_rd1", ex_rd1_o, 0);
        chk("rst_stall", stall_o, 0);
        chk_cnt("rst_cnt", 0);
        hold_i = 0; flush_i = 0; id_valid_i = 0;
        rstn = 1;
        tick();

        // Plain flow: addi
        idv(ADDI, 0, 8, 0, 0);
        id_imm_i = 32'h0000_FFFF;
        tick();
        chk("addi_ctrl", ex_ctrl_o, 15'h2860);
        chk("addi_imm", ex_imm_o, 32'h0000_FFFF);

        // Load-use: lw $8 then add $9,$8,$10
        idv(LW, 29, 8, 0, 0);
        tick();
        idv(ADD, 8, 10, 9, 1);
        #1 chk("lu_stall", stall_o, 1);
        tick();
        chk("lu_bubble", ex_valid_o, 0);
        chk("lu_stall_off", stall_o, 0);
        tick();
        chk("lu_add_v", ex_valid_o, 1);
        chk("lu_add_rd", ex_rd_o, 9);
        chk_cnt("lu_cnt", 1);

        // No false hazards
        idv(LW, 29, 0, 0, 0);
        tick();
        idv(ADD, 0, 0, 9, 1);
        #1 chk("r0_stall", stall_o, 0);
        tick();
        idv(LW, 29, 8, 0, 0);
        tick();
        idv(ORI, 7, 8, 0, 0);
        #1 chk("ori_stall", stall_o, 0);
        tick();
        chk("ori_v", ex_valid_o, 1);

        // Flush and hazard together
        idv(LW, 29, 8, 0, 0);
        tick();
        idv(ADD, 8, 10, 9, 1);
        flush_i = 1;
        #1 chk("fl_stall", stall_o, 0);
        tick();
        flush_i = 0;
        chk("fl_v", ex_valid_o, 0);
        chk_cnt("fl_cnt", 2);

        // Hold for 4 cycles with changing ID
        idv(LW, 29, 8, 0, 0);
        tick();
        hold_i = 1;
        for (int i = 0; i < 4; i++) begin
            idv(ADD, 8, 5'(i), 9, 1);
            #1 chk("hold_stall", stall_o, 0);
            tick();
            chk("hold_ctrl", ex_ctrl_o, 15'h3C00);
            chk("hold_rt", ex_rt_o, 8);
        end
        hold_i = 0;
        #1 chk("unhold_stall", stall_o, 1);
        tick();
        chk("unhold_v", ex_valid_o, 0);
        chk_cnt("hold_cnt", 3);

        // Invalid ID slot
        id_valid_i = 0;
        tick();
        chk("inv_ctrl", ex_ctrl_o, 0);

        // Reset during a stall
        idv(LW, 29, 8, 0, 0);
        tick();
        idv(ADD, 8, 10, 9, 1);
        #1 chk("mr_stall", stall_o, 1);
        rstn = 0;
        #1 chk("mr_stall0", stall_o, 0);
        tick();
        rstn = 1;
        id_valid_i = 0;
        tick();

`ifdef ID_EX_PERF_CNT_EN
        // Counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        cnt_ofs = 32'hFFFF_FFFF - m_cnt;
        #1 release dut.cnt_q;
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("wrap_cnt", bubble_cnt_o, 0);
`endif
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
